parking_lot_ctrl: RTL and testbench



---
 rtl/parking_lot_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_parking_lot_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/parking_lot_ctrl.sv
// Parking-lot occupancy controller: decodes enter/exit passages from two gate
// sensors (outer a, inner b) and keeps a saturating car count in binary and BCD.
// Ports: clk/reset_n (async active-low); a,b sensors (1 = beam blocked);
//   cars/count1/count10 occupancy; full/empty flags; enter_pulse/exit_pulse/reject
//   one-cycle strobes. All outputs are registered.
// Optional macro PARK_SYNC_EN: routes a and b through 2-flop synchronizers
//   (adds 2 cycles of sensor latency); undefined samples a and b directly.
module parking_lot_ctrl #(
  parameter int CAPACITY = 25  // lot size, 1..31
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a,
  input  logic       b,
  output logic [4:0] cars,
  output logic [3:0] count1,
  output logic [3:0] count10,
  output logic       full,
  output logic       empty,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic       reject
);

  localparam logic [4:0] CAP = 5'(CAPACITY);

  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3} state_e;

  logic [1:0] s;  // {a,b} as seen by the FSM

`ifdef PARK_SYNC_EN
  logic [1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {a, b};
      sync2_q <= sync1_q;
    end
  end
  assign s = sync2_q;
`else
  assign s = {a, b};
`endif

  state_e state_q, state_d;
  logic   enter_evt, exit_evt;

  logic [4:0] cars_q, cars_d;
  logic [3:0] count1_q, count1_d, count10_q, count10_d;
  logic       full_q, full_d, empty_q, empty_d;
  logic       enter_q, enter_d, exit_q, exit_d, reject_q, reject_d;

  // Direction FSM: a passage must go a-only, both, b-only, clear (enter) or the
  // mirror order (exit). Any other clear ends the passage without an event.
  always_comb begin
    state_d   = state_q;
    enter_evt = 1'b0;
    exit_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s == 2'b10)      state_d = IN1;
        else if (s == 2'b01) state_d = OUT1;
      end
      IN1: begin
        if (s == 2'b11)      state_d = IN2;
        else if (s != 2'b10) state_d = IDLE;
      end
      IN2: begin
        case (s)
          2'b01:   state_d = IN3;
          2'b10:   state_d = IN1;
          2'b00:   state_d = IDLE;
          default: state_d = IN2;
        endcase
      end
      IN3: begin
        case (s)
          2'b11:   state_d = IN2;
          2'b00: begin
            state_d   = IDLE;
            enter_evt = 1'b1;
          end
          2'b10:   state_d = IDLE;
          default: state_d = IN3;
        endcase
      end
      OUT1: begin
        if (s == 2'b11)      state_d = OUT2;
        else if (s != 2'b01) state_d = IDLE;
      end
      OUT2: begin
        case (s)
          2'b10:   state_d = OUT3;
          2'b01:   state_d = OUT1;
          2'b00:   state_d = IDLE;
          default: state_d = OUT2;
        endcase
      end
      OUT3: begin
        case (s)
          2'b11:   state_d = OUT2;
          2'b00: begin
            state_d  = IDLE;
            exit_evt = 1'b1;
          end
          2'b01:   state_d = IDLE;
          default: state_d = OUT3;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Count update. BCD digits track cars incrementally so no divider is needed.
  always_comb begin
    cars_d    = cars_q;
    count1_d  = count1_q;
    count10_d = count10_q;
    enter_d   = enter_evt;
    exit_d    = exit_evt;
    reject_d  = 1'b0;
    if (enter_evt) begin
      if (cars_q < CAP) begin
        cars_d = cars_q + 5'd1;
        if (count1_q == 4'd9) begin
          count1_d  = 4'd0;
          count10_d = count10_q + 4'd1;
        end else begin
          count1_d = count1_q + 4'd1;
        end
      end else begin
        reject_d = 1'b1;
      end
    end else if (exit_evt) begin
      if (cars_q != 5'd0) begin
        cars_d = cars_q - 5'd1;
        if (count1_q == 4'd0) begin
          count1_d  = 4'd9;
          count10_d = count10_q - 4'd1;
        end else begin
          count1_d = count1_q - 4'd1;
        end
      end else begin
        reject_d = 1'b1;
      end
    end
    full_d  = (cars_d == CAP);
    empty_d = (cars_d == 5'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cars_q    <= 5'd0;
      count1_q  <= 4'd0;
      count10_q <= 4'd0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      enter_q   <= 1'b0;
      exit_q    <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cars_q    <= cars_d;
      count1_q  <= count1_d;
      count10_q <= count10_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      enter_q   <= enter_d;
      exit_q    <= exit_d;
      reject_q  <= reject_d;
    end
  end

  assign cars        = cars_q;
  assign count1      = count1_q;
  assign count10     = count10_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign reject      = reject_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Bench for parking_lot_ctrl: passages are driven with 3-cycle symbol holds;
// each expected event is queued at drive time and matched when a strobe appears.
module tb_parking_lot_ctrl;

  localparam int CAP = 25;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a, b;
  logic [4:0] cars;
  logic [3:0] count1, count10;
  logic       full, empty, enter_pulse, exit_pulse, reject;

  int vectors = 0;
  int miscompares = 0;
  int m_cars = 0;

  typedef struct {
    bit en;
    bit ex;
    bit rej;
    int cars;
  } exp_t;
  exp_t expq[$];

  parking_lot_ctrl #(.CAPACITY(CAP)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b),
    .cars(cars), .count1(count1), .count10(count10),
    .full(full), .empty(empty),
    .enter_pulse(enter_pulse), .exit_pulse(exit_pulse), .reject(reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (enter_pulse || exit_pulse || reject)) begin
      if (expq.size() == 0) begin
        chk("unexpected_pulse", int'({enter_pulse, exit_pulse, reject}), 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("enter_pulse", int'(enter_pulse), int'(e.en));
        chk("exit_pulse",  int'(exit_pulse),  int'(e.ex));
        chk("reject",      int'(reject),      int'(e.rej));
        chk("ev_cars",     int'(cars),        e.cars);
        chk("ev_count1",   int'(count1),      e.cars % 10);
        chk("ev_count10",  int'(count10),     e.cars / 10);
        chk("ev_full",     int'(full),        int'(e.cars == CAP));
        chk("ev_empty",    int'(empty),       int'(e.cars == 0));
      end
    end
  end

  task automatic drive(input logic [1:0] s, input int n);
    {a, b} = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_static(input string tag);
    chk({tag, "_drain"},   expq.size(),   0);
    chk({tag, "_cars"},    int'(cars),    m_cars);
    chk({tag, "_count1"},  int'(count1),  m_cars % 10);
    chk({tag, "_count10"}, int'(count10), m_cars / 10);
    chk({tag, "_full"},    int'(full),    int'(m_cars == CAP));
    chk({tag, "_empty"},   int'(empty),   int'(m_cars == 0));
  endtask

  task automatic enter_car();
    exp_t e;
    e.en = 1'b1; e.ex = 1'b0;
    e.rej = (m_cars >= CAP);
    if (!e.rej) m_cars++;
    e.cars = m_cars;
    expq.push_back(e);
    drive(2'b10, 3); drive(2'b11, 3); drive(2'b01, 3); drive(2'b00, 6);
  endtask

  task automatic exit_car();
    exp_t e;
    e.en = 1'b0; e.ex = 1'b1;
    e.rej = (m_cars == 0);
    if (!e.rej) m_cars--;
    e.cars = m_cars;
    expq.push_back(e);
    drive(2'b01, 3); drive(2'b11, 3); drive(2'b10, 3); drive(2'b00, 6);
  endtask

  initial begin
    reset_n = 1'b0;
    a = 1'b0;
    b = 1'b0;
    #23;
    chk("rst_cars",    int'(cars),    0);
    chk("rst_count1",  int'(count1),  0);
    chk("rst_count10", int'(count10), 0);
    chk("rst_empty",   int'(empty),   1);
    chk("rst_full",    int'(full),    0);
    chk("rst_pulses",  int'({enter_pulse, exit_pulse, reject}), 0);
    reset_n = 1'b1;
    drive(2'b00, 10);
    check_static("idle");

    enter_car();
    check_static("first_entry");
    for (int i = 0; i < 8; i++) enter_car();
    check_static("at9");
    for (int i = 0; i < 10; i++) begin
      enter_car();
      if (i == 0) check_static("roll10");
    end
    check_static("at19");
    exit_car();
    check_static("at18");
    for (int i = 0; i < 7; i++) enter_car();
    check_static("at_full");
    enter_car();
    check_static("full_reject");

    // Aborted entry: back out after both beams were blocked.
    drive(2'b10, 3); drive(2'b11, 3); drive(2'b10, 3); drive(2'b00, 6);
    check_static("abort");

    for (int i = 0; i < CAP; i++) exit_car();
    check_static("drained");
    exit_car();
    check_static("empty_reject");

    // Reset in the middle of an entry, then finish its tail.
    for (int i = 0; i < 7; i++) enter_car();
    check_static("at7");
    drive(2'b10, 3); drive(2'b11, 3);
    #3;
    reset_n = 1'b0;
    m_cars = 0;
    #1;
    chk("arst_cars",  int'(cars),  0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_count1", int'(count1), 0);
    #10;
    reset_n = 1'b1;
    drive(2'b11, 2); drive(2'b01, 3); drive(2'b00, 6);
    check_static("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
